calc_entry_ctrl: RTL and testbench

- Sequencing controller between the keypad front end (debounced, one-shot key codes) and the 4-digit 7-segment multiplexer.
- Collects two decimal operands of up to 3 digits each from key presses, then adds them with a sequential BCD digit-serial adder.
- Drives the 16-bit nibble-packed display word throughout.
- A nibble value of 4'hF means the digit is blank.

---
 rtl/calc_entry_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad-to-display sequencing controller: collects two BCD operands of up to
// three digits, adds them digit-serially and shows the blanked sum.
module calc_entry_ctrl #(
  parameter int         OP_DIGITS = 3,
  parameter logic [3:0] KEY_ADD   = 4'hA,
  parameter logic [3:0] KEY_EQ    = 4'hB,
  parameter logic [3:0] KEY_CLR   = 4'hC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] display_data,
  output logic        entering_b,
  output logic        busy,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ADD     = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [1:0] MAX_CNT = 2'(OP_DIGITS);

  state_t      state, state_nxt;
  logic [11:0] op_a, op_a_nxt;
  logic [11:0] op_b, op_b_nxt;
  logic [1:0]  cnt_a, cnt_a_nxt;
  logic [1:0]  cnt_b, cnt_b_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        carry, carry_nxt;
  logic [15:0] res, res_nxt;
  logic [15:0] disp_nxt;
  logic        entering_b_nxt;
  logic        busy_nxt;
  logic        result_valid_nxt;
  logic        clr;

  logic        is_digit;
  logic [15:0] a_ext, b_ext;
  logic [3:0]  a_dig, b_dig;
  logic [4:0]  dig_sum;
  logic [15:0] res_upd;

  // One BCD digit plus carry: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin);
    logic [4:0] s;
    s = 5'(a) + 5'(b) + 5'(cin);
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    else          return {1'b0, s[3:0]};
  endfunction

  // Show the low cnt nibbles of an operand, blank the rest.
  function automatic logic [15:0] entry_display(input logic [11:0] op, input logic [1:0] cnt);
    logic [15:0] w;
    logic [15:0] d;
    w = {4'h0, op};
    d = 16'hFFFF;
    for (int i = 0; i < 4; i++)
      if (i < int'(cnt)) d[i*4 +: 4] = w[i*4 +: 4];
    return d;
  endfunction

  // Zero nibbles above the most significant nonzero digit become blank; units always shown.
  function automatic logic [15:0] blank_leading(input logic [15:0] r);
    logic [15:0] d;
    logic        seen;
    d    = r;
    seen = 1'b0;
    for (int i = 3; i > 0; i--) begin
      if (!seen && r[i*4 +: 4] == 4'h0) d[i*4 +: 4] = 4'hF;
      else                               seen = 1'b1;
    end
    return d;
  endfunction

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign a_ext    = {4'h0, op_a};
  assign b_ext    = {4'h0, op_b};
  assign a_dig    = a_ext[{idx, 2'b00} +: 4];
  assign b_dig    = b_ext[{idx, 2'b00} +: 4];
  assign dig_sum  = bcd_add(a_dig, b_dig, carry);

  always_comb begin
    res_upd = res;
    res_upd[{idx, 2'b00} +: 4] = dig_sum[3:0];
  end

  always_comb begin
    state_nxt        = state;
    op_a_nxt         = op_a;
    op_b_nxt         = op_b;
    cnt_a_nxt        = cnt_a;
    cnt_b_nxt        = cnt_b;
    idx_nxt          = idx;
    carry_nxt        = carry;
    res_nxt          = res;
    disp_nxt         = display_data;
    entering_b_nxt   = entering_b;
    busy_nxt         = busy;
    result_valid_nxt = 1'b0;
    clr              = 1'b0;

    case (state)
      ENTER_A: begin
        if (is_digit) begin
          if (cnt_a < MAX_CNT) begin
            op_a_nxt  = {op_a[7:0], key_code};
            cnt_a_nxt = cnt_a + 2'd1;
            disp_nxt  = entry_display({op_a[7:0], key_code}, cnt_a + 2'd1);
          end
        end else if (key_valid && key_code == KEY_ADD) begin
          state_nxt      = ENTER_B;
          entering_b_nxt = 1'b1;
          disp_nxt       = 16'hFFFF;
        end else if (key_valid && key_code == KEY_CLR) begin
          clr = 1'b1;
        end
      end

      ENTER_B: begin
        if (is_digit) begin
          if (cnt_b < MAX_CNT) begin
            op_b_nxt  = {op_b[7:0], key_code};
            cnt_b_nxt = cnt_b + 2'd1;
            disp_nxt  = entry_display({op_b[7:0], key_code}, cnt_b + 2'd1);
          end
        end else if (key_valid && key_code == KEY_EQ) begin
          state_nxt      = ADD;
          busy_nxt       = 1'b1;
          entering_b_nxt = 1'b0;
          idx_nxt        = 2'd0;
          carry_nxt      = 1'b0;
        end else if (key_valid && key_code == KEY_CLR) begin
          clr = 1'b1;
        end
      end

      // Digit-serial add; keys are dropped and the entry display is held.
      ADD: begin
        res_nxt   = res_upd;
        carry_nxt = dig_sum[4];
        idx_nxt   = idx + 2'd1;
        if (idx == 2'd3) begin
          state_nxt        = SHOW;
          busy_nxt         = 1'b0;
          result_valid_nxt = 1'b1;
          disp_nxt         = blank_leading(res_upd);
        end
      end

      SHOW: begin
        if (is_digit) begin
          state_nxt = ENTER_A;
          op_a_nxt  = {8'h00, key_code};
          cnt_a_nxt = 2'd1;
          op_b_nxt  = 12'h000;
          cnt_b_nxt = 2'd0;
          disp_nxt  = {12'hFFF, key_code};
        end else if (key_valid && key_code == KEY_CLR) begin
          clr = 1'b1;
        end
      end

      default: clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state        <= ENTER_A;
      op_a         <= 12'h000;
      op_b         <= 12'h000;
      cnt_a        <= 2'd0;
      cnt_b        <= 2'd0;
      idx          <= 2'd0;
      carry        <= 1'b0;
      res          <= 16'h0000;
      display_data <= 16'hFFFF;
      entering_b   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      op_a         <= op_a_nxt;
      op_b         <= op_b_nxt;
      cnt_a        <= cnt_a_nxt;
      cnt_b        <= cnt_b_nxt;
      idx          <= idx_nxt;
      carry        <= carry_nxt;
      res          <= res_nxt;
      display_data <= disp_nxt;
      entering_b   <= entering_b_nxt;
      busy         <= busy_nxt;
      result_valid <= result_valid_nxt;
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios plus random key streams checked
// against a decimal-integer model of the calculator.
module tb_calc_entry_ctrl;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam int M_A = 0, M_B = 1, M_SHOW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] display_data;
  logic        entering_b;
  logic        busy;
  logic        result_valid;

  int n_checks = 0;
  int n_errors = 0;

  int          mstate;
  int          va, ca, vb, cb;
  logic [15:0] exp_disp;

  calc_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .display_data (display_data),
    .entering_b   (entering_b),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal value v shown with n entered digits, units in the low nibble.
  function automatic logic [15:0] entry_disp(input int v, input int n);
    logic [15:0] d;
    int p;
    d = 16'hFFFF;
    p = 1;
    for (int k = 0; k < n; k++) begin
      d[k*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return d;
  endfunction

  function automatic logic [15:0] result_disp(input int s);
    int nd;
    nd = (s >= 1000) ? 4 : (s >= 100) ? 3 : (s >= 10) ? 2 : 1;
    return entry_disp(s, nd);
  endfunction

  task automatic model_reset();
    mstate = M_A; va = 0; ca = 0; vb = 0; cb = 0;
    exp_disp = 16'hFFFF;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_disp"}, display_data, exp_disp);
    check_eq({tag, "_entb"}, 16'(entering_b), 16'(mstate == M_B));
    check_eq({tag, "_busy"}, 16'(busy), 16'h0);
    check_eq({tag, "_rv"}, 16'(result_valid), 16'h0);
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called one negedge after the '=' edge; ends one negedge after the result pulse.
  task automatic run_add(input bit inject);
    check_eq("add_busy0", 16'(busy), 16'h1);
    check_eq("add_entb0", 16'(entering_b), 16'h0);
    for (int i = 0; i < 3; i++) begin
      if (inject && i == 0) begin
        key_valid = 1'b1;
        key_code  = 4'($urandom_range(0, 12));
      end
      @(negedge clk);
      key_valid = 1'b0;
      check_eq("add_busy", 16'(busy), 16'h1);
      check_eq("add_rv_early", 16'(result_valid), 16'h0);
    end
    @(negedge clk);
    check_eq("sum_rv", 16'(result_valid), 16'h1);
    check_eq("sum_busy", 16'(busy), 16'h0);
    check_eq("sum_disp", display_data, exp_disp);
    @(negedge clk);
  endtask

  task automatic apply_key(input logic [3:0] c, input bit inject);
    press(c);
    if (c <= 4'd9) begin
      if (mstate == M_A) begin
        if (ca < 3) begin va = va * 10 + int'(c); ca++; end
        exp_disp = entry_disp(va, ca);
      end else if (mstate == M_B) begin
        if (cb < 3) begin vb = vb * 10 + int'(c); cb++; end
        exp_disp = entry_disp(vb, cb);
      end else begin
        va = int'(c); ca = 1; vb = 0; cb = 0; mstate = M_A;
        exp_disp = entry_disp(va, ca);
      end
    end else if (c == KEY_CLR) begin
      model_reset();
    end else if (c == KEY_ADD && mstate == M_A) begin
      mstate = M_B;
      exp_disp = 16'hFFFF;
    end else if (c == KEY_EQ && mstate == M_B) begin
      mstate = M_SHOW;
      exp_disp = result_disp(va + vb);
      run_add(inject);
    end
    check_idle("key");
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle("reset");
  endtask

  initial begin
    model_reset();
    do_reset(2);

    // Entry and digit-limit behaviour
    apply_key(4'h1, 0); check_eq("a1", display_data, 16'hFFF1);
    apply_key(4'h2, 0); check_eq("a12", display_data, 16'hFF12);
    apply_key(4'h3, 0); check_eq("a123", display_data, 16'hF123);
    apply_key(4'h4, 0); check_eq("a123_full", display_data, 16'hF123);
    apply_key(4'hE, 0); check_eq("a_keyE", display_data, 16'hF123);
    apply_key(KEY_EQ, 0);
    apply_key(KEY_ADD, 0);
    check_eq("b_start_entb", 16'(entering_b), 16'h1);
    check_eq("b_start_disp", display_data, 16'hFFFF);
    apply_key(4'h4, 0); apply_key(4'h5, 0); apply_key(4'h6, 0);
    apply_key(KEY_ADD, 0);
    apply_key(KEY_EQ, 0);
    check_eq("sum579", display_data, 16'hF579);

    // Carry chain through every digit, with a key injected mid-add
    apply_key(KEY_CLR, 0);
    for (int i = 0; i < 3; i++) apply_key(4'h9, 0);
    apply_key(KEY_ADD, 0);
    for (int i = 0; i < 3; i++) apply_key(4'h9, 0);
    apply_key(KEY_EQ, 1);
    check_eq("sum1998", display_data, 16'h1998);

    // Empty operands, SHOW-state digit, clear
    apply_key(KEY_CLR, 0);
    apply_key(KEY_ADD, 0);
    apply_key(KEY_EQ, 0);
    check_eq("sum_zero", display_data, 16'hFFF0);
    apply_key(KEY_EQ, 0);
    apply_key(4'h7, 0);
    check_eq("show_digit", display_data, 16'hFFF7);
    apply_key(KEY_CLR, 0);
    check_eq("clr", display_data, 16'hFFFF);

    apply_key(4'h5, 0); apply_key(KEY_ADD, 0); apply_key(KEY_EQ, 0);
    check_eq("b_empty", display_data, 16'hFFF5);
    apply_key(KEY_CLR, 0);
    apply_key(4'h0, 0); apply_key(4'h0, 0); apply_key(4'h5, 0);
    check_eq("a005", display_data, 16'hF005);
    apply_key(KEY_ADD, 0); apply_key(4'h0, 0); apply_key(KEY_EQ, 0);
    check_eq("lead_zero", display_data, 16'hFFF5);

    // Reset in the middle of an add
    apply_key(KEY_CLR, 0);
    apply_key(4'h8, 0); apply_key(KEY_ADD, 0); apply_key(4'h3, 0);
    press(KEY_EQ);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle("midadd_rst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midadd_no_rv", 16'(result_valid), 16'h0);
      check_eq("midadd_disp", display_data, 16'hFFFF);
    end

    // Random key streams
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(0, 19));
      if (r < 12)      c = 4'($urandom_range(0, 9));
      else if (r < 15) c = KEY_ADD;
      else if (r < 18) c = KEY_EQ;
      else if (r < 19) c = KEY_CLR;
      else             c = 4'($urandom_range(13, 15));
      apply_key(c, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
